// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and line constants, shared by the transmitter and the receiver
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   localparam logic LINE_IDLE = 1'b1;
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } uart_tx_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: request/status/serial-line bundle of the UART transmitter
interface uart_tx_if #(parameter int DBIT = 8) ();
   logic            tx_start;
   logic            s_tick;
   logic [DBIT-1:0] din;
   logic            tx_done_tick;
   logic            tx_busy;
   logic            tx;
   modport master (output tx_start, s_tick, din, input tx_done_tick, tx_busy, tx);
   modport slave (input tx_start, s_tick, din, output tx_done_tick, tx_busy, tx);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter paced by an external 16x s_tick; even parity bit with UART_TX_PARITY_EN
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input logic      clk,
   input logic      reset,
   uart_tx_if.slave bus
);
   localparam int SW = $clog2(SB_TICK) < 4 ? 4 : $clog2(SB_TICK);
   localparam int NW = $clog2(DBIT);
   uart_tx_state_t  state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            tx_q, tx_d;
   logic            done;
   logic            bit_end;
`ifdef UART_TX_PARITY_EN
   logic            p_q, p_d;
`endif
   assign bit_end = bus.s_tick && s_q == SW'(OVERSAMPLE - 1);
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      done    = 1'b0;
`ifdef UART_TX_PARITY_EN
      p_d     = p_q;
`endif
      case (state_q)
         IDLE: if (bus.tx_start) begin
            state_d = START;
            s_d     = '0;
            b_d     = bus.din;
`ifdef UART_TX_PARITY_EN
            p_d     = ^bus.din;
`endif
         end
         START: if (bit_end) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
         end else if (bus.s_tick) s_d = s_q + 1'b1;
         DATA: if (bit_end) begin
            s_d = '0;
            b_d = b_q >> 1;
            n_d = n_q + 1'b1;
            if (n_q == NW'(DBIT - 1)) begin
               n_d = n_q;
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end else if (bus.s_tick) s_d = s_q + 1'b1;
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            state_d = STOP;
            s_d     = '0;
         end else if (bus.s_tick) s_d = s_q + 1'b1;
`endif
         STOP: if (bus.s_tick && s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            done    = 1'b1;
         end else if (bus.s_tick) s_d = s_q + 1'b1;
         default: state_d = IDLE;
      endcase
      // line level is registered, so it follows the state being entered
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? b_d[0] : LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      tx_d = state_d == PARITY ? p_d : tx_d;
`endif
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
         p_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         p_q     <= p_d;
`endif
      end
   end
   assign bus.tx_done_tick = done;
   assign bus.tx_busy      = state_q != IDLE;
   assign bus.tx           = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame vectors plus busy, back-to-back, reset-abort and long-stop sequences
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   typedef struct {
      logic [7:0] din;
      int         div;
      logic       par;
      int         done_np;
      int         done_p;
   } vec_t;
   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       tick  = 1'b0;
   logic       st0   = 1'b0;
   logic       st1   = 1'b0;
   logic [7:0] dinv  = 8'h00;
   int         checks = 0;
   int         errors = 0;
   always #5 clk = ~clk;
   uart_tx_if #(.DBIT(8)) u0 ();
   uart_tx_if #(.DBIT(8)) u1 ();
   assign u0.tx_start = st0;
   assign u0.s_tick   = tick;
   assign u0.din      = dinv;
   assign u1.tx_start = st1;
   assign u1.s_tick   = tick;
   assign u1.din      = dinv;
   uart_tx #(.DBIT(8), .SB_TICK(16)) dut0 (.clk(clk), .reset(reset), .bus(u0.slave));
   uart_tx #(.DBIT(8), .SB_TICK(32)) dut1 (.clk(clk), .reset(reset), .bus(u1.slave));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_frame(input bit sel, input logic [7:0] d, input int div, input logic par,
                            input int exp_done, input int inj, input bit chain, input int abort_at);
      int   sb = sel ? 32 : 16;
      int   total = 16 + 16 * 8 + 16 * PAR + sb;
      int   t = 0;
      int   cyc = 0;
      int   b;
      bit   fin = 0;
      logic stv, etx, edone, otx, obusy, odone;
      while (!fin) begin
         @(negedge clk);
         tick = (cyc % div) == div - 1;
         dinv = cyc == 0 ? d : 8'hFF;
         stv  = cyc == 0 || (tick && (t == inj || (chain && t == total - 1)));
         st0  = sel ? 1'b0 : stv;
         st1  = sel ? stv : 1'b0;
         if (cyc > 0 && t == abort_at) begin
            reset = 1'b0;
            #1;
            chk("abort_tx", sel ? u1.tx : u0.tx, 1);
            chk("abort_busy", sel ? u1.tx_busy : u0.tx_busy, 0);
            chk("abort_done", sel ? u1.tx_done_tick : u0.tx_done_tick, 0);
            @(negedge clk);
            reset = 1'b1;
            st0   = 1'b0;
            st1   = 1'b0;
            return;
         end
         #1;
         otx   = sel ? u1.tx : u0.tx;
         obusy = sel ? u1.tx_busy : u0.tx_busy;
         odone = sel ? u1.tx_done_tick : u0.tx_done_tick;
         b     = t / 16;
         etx   = cyc == 0 ? 1'b1 : b == 0 ? 1'b0 : b <= 8 ? d[b-1] :
                 (PAR == 1 && b == 9) ? par : 1'b1;
         edone = cyc != 0 && tick && t == total - 1;
         chk($sformatf("tx %02h c%0d", d, cyc), otx, etx);
         chk($sformatf("busy %02h c%0d", d, cyc), obusy, cyc != 0);
         chk($sformatf("done %02h c%0d", d, cyc), odone, edone);
         if (edone) begin
            fin = 1;
            chk($sformatf("frame_len %02h", d), cyc, exp_done);
         end
         if (cyc != 0 && tick) t++;
         cyc++;
      end
      if (!chain) begin
         @(negedge clk);
         st0  = 1'b0;
         st1  = 1'b0;
         tick = 1'b1;
         #1;
         chk("idle_tx", sel ? u1.tx : u0.tx, 1);
         chk("idle_busy", sel ? u1.tx_busy : u0.tx_busy, 0);
      end
   endtask

   initial begin
      vec_t v[6];
      v[0] = '{8'hA3, 1, 1'b0, 160, 176};
      v[1] = '{8'h55, 1, 1'b0, 160, 176};
      v[2] = '{8'h01, 4, 1'b1, 639, 703};
      v[3] = '{8'hA5, 1, 1'b0, 160, 176};
      v[4] = '{8'h07, 1, 1'b1, 160, 176};
      v[5] = '{8'h00, 2, 1'b0, 319, 351};
      #1 reset = 1'b0;
      tick = 1'b1;
      st0  = 1'b1;
      st1  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_tx0", u0.tx, 1);
      chk("rst_busy0", u0.tx_busy, 0);
      chk("rst_done0", u0.tx_done_tick, 0);
      chk("rst_tx1", u1.tx, 1);
      chk("rst_busy1", u1.tx_busy, 0);
      chk("rst_done1", u1.tx_done_tick, 0);
      st0  = 1'b0;
      st1  = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_frame(0, 8'h00, 1, 1'b0, PAR ? 176 : 160, 50, 1, -1);
      run_frame(0, 8'hA3, 1, 1'b0, PAR ? 176 : 160, -1, 0, 70);
      for (int i = 0; i < 6; i++)
         run_frame(0, v[i].din, v[i].div, v[i].par, PAR ? v[i].done_p : v[i].done_np, -1, 0, -1);
      run_frame(1, 8'h80, 1, 1'b1, PAR ? 192 : 176, -1, 0, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART path in the finite-state-machine module set. It accepts a parallel data word on a one-cycle start strobe and shifts it out on a single line as start bit, data bits (LSB first), optional parity and stop bit(s). Bit timing comes from an external oversampling tick, `s_tick`, that pulses at 16× the baud rate; the transmitter generates no baud timing of its own. It is the sending counterpart of the oversampling UART receiver and is paced by the same baud tick source.

## Interface
- `DBIT`, 8: number of data bits per frame (5–9).
- `SB_TICK`, 16: stop-bit length in `s_tick` pulses; 16, 24 or 32 give 1, 1.5 or 2 stop bits.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  one-cycle request to send `din`; honoured only in IDLE.
- `s_tick`  in  1  oversampling enable, one `clk` wide, 16 per bit period.
- `din`  in  DBIT  word to send; sampled in the cycle `tx_start` is accepted.
- `tx_done_tick`  out  1  one-cycle pulse when the final stop tick completes.
- `tx_busy`  out  1  high whenever the state is not IDLE.
- `tx`  out  1  serial line, registered, idle-high.

## Operation
- The state machine has these states: IDLE, START, DATA, PARITY (only when configured in), STOP.
- IDLE:
  - `tx` = 1.
  - On `tx_start`: load the shift register `b_reg` ← `din`, clear the tick counter `s_reg`, and go to START.
- START:
  - `tx` = 0.
  - Each `s_tick` increments `s_reg`.
  - At `s_tick` with `s_reg` = 15: clear `s_reg`, clear the bit counter `n_reg`, and go to DATA.
- DATA:
  - `tx` = `b_reg[0]`.
  - At `s_tick` with `s_reg` = 15: shift `b_reg` right by 1 and clear `s_reg`.
  - If `n_reg` = DBIT−1, go to PARITY, or to STOP when parity is compiled out. Otherwise increment `n_reg`.
- PARITY:
  - `tx` = the parity register.
  - Lasts 16 ticks, then go to STOP.
- STOP:
  - `tx` = 1.
  - At `s_tick` with `s_reg` = SB_TICK−1: go to IDLE and assert `tx_done_tick` in that same cycle.
- Ticks are counted only when `s_tick` = 1. Without ticks, the FSM holds its state indefinitely.
- `tx_start` outside IDLE is ignored. `din` changes after acceptance do not affect the frame.
- Counter widths:
  - `s_reg` is `$clog2(SB_TICK)` bits, with a minimum of 4.
  - `n_reg` is `$clog2(DBIT)` bits.
  - Counter compares are exact; no counter wraps past its terminal value.

## Timing
- Reset values: state IDLE, `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0, all counters and `b_reg` = 0.
- `tx` is registered: it falls on the clock edge after the cycle in which `tx_start` is accepted.
- Frame length in `s_tick` pulses is 16 + 16·DBIT (+16 with parity) + SB_TICK. For the defaults this is 160 (176 with parity).
- `tx_done_tick` is combinational from the state and counters.
  - It is high for exactly one cycle: the cycle carrying the final stop `s_tick`.
  - `tx_start` in that same cycle is ignored, because the state is still STOP.
  - The earliest next acceptance is the following cycle, so the back-to-back gap is 1 `clk`.
- Reset mid-frame: `tx` returns to 1 asynchronously, no `tx_done_tick` is issued, and the frame is abandoned.
- The `s_tick` pulse that accepts nothing in IDLE is not counted toward the next frame.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- When defined:
  - The PARITY state exists.
  - Even parity, the XOR of the DBIT data bits, is computed when `din` is accepted.
  - The parity bit is sent for 16 ticks between the last data bit and the stop bit(s).
- When undefined:
  - The PARITY state and the parity register are absent.
  - DATA goes directly to STOP.

## Structure
- Package `uart_pkg`:
  - State enum `uart_tx_state_t`.
  - Localparam `OVERSAMPLE` = 16.
  - Idle line level constant `LINE_IDLE` = 1'b1.
  - The receiver shares this package.
- No sub-module. The baud tick generator stays external and is instantiated alongside this block at the top level.

## Test plan
- **Basic frame:** defaults, `s_tick` every cycle, `din` = 0x55, `tx_start` pulse.
  - `tx` is 0 for 16 cycles, then 1,0,1,0,1,0,1,0 for 16 cycles each, then 1 for 16 cycles.
  - `tx_done_tick` pulses at tick 160.
  - `tx_busy` is high throughout.
- **Slow tick:** `s_tick` every 4th cycle, `din` = 0x01.
  - Each bit lasts 64 `clk` cycles.
  - The first data bit is 1 and the rest are 0.
  - The frame takes 640 cycles.
- **Busy rejection and back-to-back:** `tx_start` with `din` = 0xFF at tick 50 of a 0x00 frame.
  - The 0xFF request is ignored and the 0x00 frame is unchanged.
  - A `tx_start` in the `tx_done_tick` cycle is ignored; one issued in the next cycle starts a new frame with a 1-cycle gap.
- **Reset mid-frame:** assert `reset` low during DATA bit 3.
  - `tx` = 1 immediately, `tx_busy` = 0, no done pulse.
  - After release, a new 0xA3 frame transmits correctly.
- **Stop length:** `SB_TICK` = 32, `din` = 0x80.
  - The stop bit lasts 32 ticks.
  - `tx_done_tick` pulses at tick 176.
- **Parity (`UART_TX_PARITY_EN`):**
  - `din` = 0xA5 gives parity bit 0.
  - `din` = 0x07 gives parity bit 1.
  - Frame length is 176 ticks.
